// File: rtl/rr_arbiter_4_1_if.sv
// Handshake bundle between four producer channels, the round-robin arbiter and its consumer.
// Latency: none (wires only).
// Backpressure: carries in_ready per channel and out_ready from the consumer.
// Ports: in_valid/d0..d3 (channels -> arbiter), in_ready/sel (arbiter -> channels/mux),
//        out_valid/out_data/out_chan (arbiter -> consumer), out_ready (consumer -> arbiter).
interface rr_arbiter_4_1_if #(
    parameter int width = 8
);
    logic [3:0]       in_valid;
    logic [width-1:0] d0;
    logic [width-1:0] d1;
    logic [width-1:0] d2;
    logic [width-1:0] d3;
    logic [3:0]       in_ready;
    logic [1:0]       sel;
    logic             out_valid;
    logic [width-1:0] out_data;
    logic [1:0]       out_chan;
    logic             out_ready;

    // Arbiter side.
    modport slave (
        input  in_valid, d0, d1, d2, d3, out_ready,
        output in_ready, sel, out_valid, out_data, out_chan
    );

    // Producer/consumer side.
    modport master (
        output in_valid, d0, d1, d2, d3, out_ready,
        input  in_ready, sel, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/rr_arbiter_4_1.sv
// 4:1 data mux steered by a 2-bit select.
// Latency: combinational.
// Backpressure: none.
// Ports: sel_i (select), d0_i..d3_i (data in), y_o (selected data).
module mux_4_1 #(
    parameter int width = 8
) (
    input  logic [1:0]       sel_i,
    input  logic [width-1:0] d0_i,
    input  logic [width-1:0] d1_i,
    input  logic [width-1:0] d2_i,
    input  logic [width-1:0] d3_i,
    output logic [width-1:0] y_o
);
    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end
endmodule

// Round-robin arbiter over four valid/ready channels feeding a registered output stage.
// Latency: one cycle from in_ready[i] to out_valid; one word per cycle sustained.
// Backpressure: out_ready=0 while full stalls the output register and deasserts all in_ready.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport of rr_arbiter_4_1_if).
module rr_arbiter_4_1 #(
    parameter int width = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_arbiter_4_1_if.slave   bus
);
    // Output-register occupancy; the state is exactly out_valid.
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [width-1:0] data_q,  data_d;
    logic [1:0]       chan_q,  chan_d;
    logic [1:0]       ptr_q,   ptr_d;

    logic             load;
    logic             grant_any;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic             found;
    logic [width-1:0] mux_dat;

    // A new word may land when the register is empty or is being drained this cycle.
    assign load      = (state_q == EMPTY) || bus.out_ready;
    assign grant_any = |bus.in_valid;

    // Rotating priority search starting at ptr_q; idx wraps naturally in 2 bits.
    always_comb begin
        grant = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && bus.in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign bus.sel = grant_any ? grant : 2'd0;

    // Mux steered by the same select that is published, so both always agree.
    mux_4_1 #(.width(width)) u_mux (
        .sel_i (bus.sel),
        .d0_i  (bus.d0),
        .d1_i  (bus.d1),
        .d2_i  (bus.d2),
        .d3_i  (bus.d3),
        .y_o   (mux_dat)
    );

    // rst_n gates acceptance so no channel believes a word was taken during reset.
    assign bus.in_ready = (load && grant_any && rst_n) ? (4'b0001 << grant) : 4'b0000;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (grant_any) begin
                state_d = FULL;
                data_d  = mux_dat;
                chan_d  = grant;
                ptr_d   = grant + 2'd1;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
endmodule

// File: tb/tb_rr_arbiter_4_1.sv
// Bench for rr_arbiter_4_1: directed vector table, then random traffic against a reference model.
// Latency: n/a.
// Backpressure: random out_ready in the random phase.
module tb_rr_arbiter_4_1;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arbiter_4_1_if #(.width(W)) bus ();

    rr_arbiter_4_1 #(.width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic        ordy;
        logic [31:0] d;      // {d3,d2,d1,d0}
        logic [1:0]  e_sel;
        logic [3:0]  e_rdy;
        logic        e_ov;   // values after the edge
        logic [1:0]  e_chan;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] iv, input logic ordy, input logic [31:0] d,
                       input logic [1:0] es, input logic [3:0] er, input logic eov,
                       input logic [1:0] ec, input logic [7:0] ed);
        vec_t v;
        v.rst = r; v.iv = iv; v.ordy = ordy; v.d = d;
        v.e_sel = es; v.e_rdy = er; v.e_ov = eov; v.e_chan = ec; v.e_dat = ed;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [3:0] iv, input logic ordy, input logic [31:0] d);
        rst_n         = r;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.d0        = d[7:0];
        bus.d1        = d[15:8];
        bus.d2        = d[23:16];
        bus.d3        = d[31:24];
    endtask

    // Reference model state (random phase)
    int          m_ov, m_dat, m_chan, m_ptr;
    logic [3:0]  pend;
    logic [7:0]  pdat [4];
    int          waits [4];

    initial begin
        logic [31:0] da, d5c, dff, dcur;
        logic [3:0]  erdy;
        logic        r, ordy, ld;
        int          g, esel;

        da  = 32'hA3A2A1A0;
        d5c = 32'hA35CA1A0;
        dff = 32'hA3A2A1FF;

        // reset and idle
        add(0, 4'b0000, 0, da, 0, 4'b0000, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) add(1, 4'b0000, 0, da, 0, 4'b0000, 0, 0, 8'h00);
        // all channels valid, full throughput rotation
        for (int i = 0; i < 8; i++)
            add(1, 4'b1111, 1, da, 2'(i % 4), 4'(1 << (i % 4)), 1, 2'(i % 4), 8'(8'hA0 + i % 4));
        // drain to empty: data/chan hold
        add(1, 4'b0000, 1, da, 0, 4'b0000, 0, 3, 8'hA3);
        // ch2 only, stalled for 4 cycles, then released
        add(1, 4'b0100, 0, d5c, 2, 4'b0100, 1, 2, 8'h5C);
        for (int i = 0; i < 3; i++) add(1, 4'b0100, 0, d5c, 2, 4'b0000, 1, 2, 8'h5C);
        add(1, 4'b0100, 1, d5c, 2, 4'b0100, 1, 2, 8'h5C);
        // ptr=3 now: wrap-around 3 then 0
        add(1, 4'b1001, 1, da, 3, 4'b1000, 1, 3, 8'hA3);
        add(1, 4'b1001, 1, da, 0, 4'b0001, 1, 0, 8'hA0);
        // ch1/ch2 with out_ready toggling
        add(1, 4'b0110, 1, da, 1, 4'b0010, 1, 1, 8'hA1);
        add(1, 4'b0110, 0, da, 2, 4'b0000, 1, 1, 8'hA1);
        add(1, 4'b0110, 1, da, 2, 4'b0100, 1, 2, 8'hA2);
        add(1, 4'b0110, 0, da, 1, 4'b0000, 1, 2, 8'hA2);
        add(1, 4'b0110, 1, da, 1, 4'b0010, 1, 1, 8'hA1);
        // load 0xFF, then reset while full, then first grant searches from 0
        add(1, 4'b0001, 1, dff, 0, 4'b0001, 1, 0, 8'hFF);
        add(0, 4'b0001, 0, dff, 0, 4'b0000, 0, 0, 8'h00);
        add(1, 4'b1010, 1, da, 1, 4'b0010, 1, 1, 8'hA1);

        drive(0, 4'b0000, 0, da);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].ordy, tbl[i].d);
            @(negedge clk);
            chk($sformatf("v%0d sel", i), 32'(bus.sel), 32'(tbl[i].e_sel));
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d out_chan", i), 32'(bus.out_chan), 32'(tbl[i].e_chan));
            chk($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(tbl[i].e_dat));
        end

        // Random phase: start from a clean reset.
        drive(0, 4'b0000, 0, da);
        @(posedge clk); #1;
        m_ov = 0; m_dat = 0; m_chan = 0; m_ptr = 0;
        pend = 4'b0000;
        for (int c = 0; c < 4; c++) begin pdat[c] = 8'h00; waits[c] = 0; end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Channels hold their word until accepted; idle channels may raise a new one.
            for (int c = 0; c < 4; c++)
                if (!pend[c] && ($urandom % 3 == 0)) begin
                    pend[c] = 1'b1;
                    pdat[c] = 8'($urandom);
                end
            r    = ($urandom % 60) != 0;
            ordy = $urandom % 2;
            dcur = {pdat[3], pdat[2], pdat[1], pdat[0]};
            drive(r, pend, ordy, dcur);

            // Grant: nearest pending channel at or after the pointer, going round.
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            ld   = (m_ov == 0) || ordy;
            esel = (g >= 0) ? g : 0;
            erdy = (r && ld && g >= 0) ? 4'(1 << g) : 4'b0000;

            @(negedge clk);
            chk("rnd sel", 32'(bus.sel), 32'(esel));
            chk("rnd in_ready", 32'(bus.in_ready), 32'(erdy));
            chk("rnd out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov != 0) begin
                chk("rnd out_data", 32'(bus.out_data), 32'(m_dat));
                chk("rnd out_chan", 32'(bus.out_chan), 32'(m_chan));
            end

            @(posedge clk); #1;
            if (!r) begin
                m_ov = 0; m_dat = 0; m_chan = 0; m_ptr = 0;
                for (int c = 0; c < 4; c++) waits[c] = 0;
            end else if (ld) begin
                if (g >= 0) begin
                    for (int c = 0; c < 4; c++) if (pend[c]) waits[c]++;
                    chk("rnd fairness", 32'(waits[g] <= 4), 32'd1);
                    waits[g] = 0;
                    m_ov   = 1;
                    m_dat  = pdat[g];
                    m_chan = g;
                    m_ptr  = (g + 1) % 4;
                    pend[g] = 1'b0;
                end else begin
                    m_ov = 0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
